// File: rtl/m_cp0_if.sv
// Pipeline-to-CP0 bundle: mfc0/mtc0 access, memory-stage exception inputs,
// interrupt lines, and the request / return-address outputs.
interface m_cp0_if;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        exl_clr;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, exl_clr, hw_int,
        input  cp0_rdata, req, epc_out
    );

    modport slave (
        input  en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, exl_clr, hw_int,
        output cp0_rdata, req, epc_out
    );
endinterface

// File: rtl/m_cp0.sv
// Coprocessor-0 register block (SR, Cause, EPC, PRId) with exception/interrupt
// arbitration. Optional macro CP0_EPC_BYPASS_EN forwards an mtc0 EPC to epc_out.
module m_cp0 #(
    parameter logic [31:0] PRID = 32'h2023_0007
) (
    input logic    clk,
    input logic    reset,
    m_cp0_if.slave bus
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] pc_adj;
    logic [31:0] epc_next;

    assign int_req = sr_ie & ~sr_exl & (|(sr_im & bus.hw_int));
    assign exc_req = ~sr_exl & (bus.exc_code_in != 5'd0);
    assign req     = int_req | exc_req;

    // A delay-slot victim returns to its branch, so step back one word.
    assign pc_adj   = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
    assign epc_next = {pc_adj[31:2], 2'b00};

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; later statements in the block override earlier ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= bus.hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bus.bd_in;
                cause_exc <= int_req ? 5'd0 : bus.exc_code_in;
                epc       <= epc_next;
            end else begin
                if (bus.en && bus.cp0_addr == ADDR_SR) begin
                    sr_im  <= bus.cp0_wdata[15:10];
                    sr_exl <= bus.cp0_wdata[1];
                    sr_ie  <= bus.cp0_wdata[0];
                end
                if (bus.en && bus.cp0_addr == ADDR_EPC) begin
                    epc <= bus.cp0_wdata;
                end
                // Placed after the SR write so eret wins over a written EXL.
                if (bus.exl_clr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // NOTE: rdata gets a default before the case so no latch is inferred.
    always_comb begin
        bus.cp0_rdata = 32'h0;
        case (bus.cp0_addr)
            ADDR_SR:    bus.cp0_rdata = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
            ADDR_CAUSE: bus.cp0_rdata = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'b00};
            ADDR_EPC:   bus.cp0_rdata = epc;
            ADDR_PRID:  bus.cp0_rdata = PRID;
            default:    bus.cp0_rdata = 32'h0;
        endcase
    end

    assign bus.req = req;

`ifdef CP0_EPC_BYPASS_EN
    assign bus.epc_out = (bus.en && bus.cp0_addr == ADDR_EPC && !req) ? bus.cp0_wdata : epc;
`else
    assign bus.epc_out = epc;
`endif

endmodule

// File: tb/tb_m_cp0.sv
// Scoreboard bench for m_cp0: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_m_cp0;
    localparam logic [31:0] PRID_VAL = 32'h2023_0007;
    localparam int SEL_RDATA = 0;
    localparam int SEL_REQ   = 1;
    localparam int SEL_EPC   = 2;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    m_cp0_if bus ();

    m_cp0 #(.PRID(PRID_VAL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   vectors;
    int   miscompares;

    task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        bus.en          = 1'b0;
        bus.cp0_addr    = 5'd0;
        bus.cp0_wdata   = 32'h0;
        bus.vpc         = 32'h0;
        bus.bd_in       = 1'b0;
        bus.exc_code_in = 5'd0;
        bus.exl_clr     = 1'b0;
        bus.hw_int      = 6'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable half a cycle after inputs are driven.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RDATA: act = bus.cp0_rdata;
                SEL_REQ:   act = {31'h0, bus.req};
                default:   act = bus.epc_out;
            endcase
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %08h, expected %08h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state
        idle(); bus.cp0_addr = 5'd12;
        expect_out("rst_sr", SEL_RDATA, 32'h0);
        expect_out("rst_req", SEL_REQ, 32'h0);
        expect_out("rst_epc", SEL_EPC, 32'h0);
        tick();
        idle(); bus.cp0_addr = 5'd13; expect_out("rst_cause", SEL_RDATA, 32'h0); tick();
        idle(); bus.cp0_addr = 5'd14; expect_out("rst_epcreg", SEL_RDATA, 32'h0); tick();
        idle(); bus.cp0_addr = 5'd15; expect_out("prid", SEL_RDATA, PRID_VAL); tick();

        // Enable all interrupts, then raise line 2
        idle(); bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_FC01;
        expect_out("mtc0_sr_req", SEL_REQ, 32'h0);
        tick();
        idle(); bus.hw_int = 6'b000100; bus.vpc = 32'h0000_1000; bus.cp0_addr = 5'd12;
        expect_out("sr_after_mtc0", SEL_RDATA, 32'h0000_FC01);
        expect_out("int_req", SEL_REQ, 32'h1);
        tick();
        idle(); bus.hw_int = 6'b000100; bus.cp0_addr = 5'd13;
        expect_out("int_req_drop", SEL_REQ, 32'h0);
        expect_out("int_cause", SEL_RDATA, 32'h0000_1000);
        expect_out("int_epc", SEL_EPC, 32'h0000_1000);
        tick();
        idle(); bus.cp0_addr = 5'd12; bus.exl_clr = 1'b1;
        expect_out("int_sr_exl", SEL_RDATA, 32'h0000_FC03);
        tick();
        idle(); bus.cp0_addr = 5'd12;
        expect_out("eret_sr", SEL_RDATA, 32'h0000_FC01);
        expect_out("eret_req", SEL_REQ, 32'h0);
        tick();

        // Exception in a delay slot
        idle(); bus.exc_code_in = 5'd4; bus.vpc = 32'h0000_3008; bus.bd_in = 1'b1;
        expect_out("exc_req", SEL_REQ, 32'h1);
        tick();
        idle(); bus.cp0_addr = 5'd13; bus.exl_clr = 1'b1;
        expect_out("bd_cause", SEL_RDATA, 32'h8000_0010);
        expect_out("bd_epc", SEL_EPC, 32'h0000_3004);
        tick();

        // Interrupt beats exception
        idle(); bus.hw_int = 6'b000001; bus.exc_code_in = 5'd10; bus.vpc = 32'h0000_2000;
        expect_out("both_req", SEL_REQ, 32'h1);
        tick();
        idle(); bus.cp0_addr = 5'd13; bus.exl_clr = 1'b1;
        expect_out("both_cause", SEL_RDATA, 32'h0000_0400);
        expect_out("both_epc", SEL_EPC, 32'h0000_2000);
        tick();

        // Request overrides a same-cycle mtc0 EPC
        idle(); bus.en = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h0000_3100;
        bus.exc_code_in = 5'd8; bus.vpc = 32'h0000_3020;
        expect_out("ovr_req", SEL_REQ, 32'h1);
        expect_out("ovr_epc_now", SEL_EPC, 32'h0000_2000);
        tick();
        idle(); bus.cp0_addr = 5'd13; bus.exl_clr = 1'b1;
        expect_out("ovr_epc", SEL_EPC, 32'h0000_3020);
        expect_out("ovr_cause", SEL_RDATA, 32'h0000_0020);
        expect_out("ovr_req_drop", SEL_REQ, 32'h0);
        tick();
        idle(); bus.cp0_addr = 5'd12;
        expect_out("ovr_eret_sr", SEL_RDATA, 32'h0000_FC01);
        tick();

        // mtc0 EPC visibility on epc_out
        idle(); bus.en = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h0000_4000;
`ifdef CP0_EPC_BYPASS_EN
        expect_out("epc_bypass", SEL_EPC, 32'h0000_4000);
`else
        expect_out("epc_nobypass", SEL_EPC, 32'h0000_3020);
`endif
        tick();
        idle(); bus.cp0_addr = 5'd14;
        expect_out("epc_written", SEL_RDATA, 32'h0000_4000);
        expect_out("epc_out_written", SEL_EPC, 32'h0000_4000);
        tick();

        // EPC wraps below zero; nested exception ignored
        idle(); bus.exc_code_in = 5'd1; bus.bd_in = 1'b1; bus.vpc = 32'h0000_0002;
        expect_out("wrap_req", SEL_REQ, 32'h1);
        tick();
        idle(); bus.exc_code_in = 5'd5; bus.vpc = 32'h0000_5000; bus.cp0_addr = 5'd13;
        expect_out("nested_req", SEL_REQ, 32'h0);
        expect_out("wrap_cause", SEL_RDATA, 32'h8000_0004);
        expect_out("wrap_epc", SEL_EPC, 32'hFFFF_FFFC);
        tick();
        idle(); bus.en = 1'b1; bus.cp0_addr = 5'd13; bus.cp0_wdata = 32'hFFFF_FFFF;
        expect_out("nested_epc", SEL_EPC, 32'hFFFF_FFFC);
        tick();
        idle(); bus.cp0_addr = 5'd13;
        expect_out("cause_ro", SEL_RDATA, 32'h8000_0004);
        tick();

        // mtc0 SR together with eret: write then clear EXL
        idle(); bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'hFFFF_FFFF;
        bus.exl_clr = 1'b1;
        expect_out("sr_pre_clr", SEL_RDATA, 32'h0000_FC03);
        tick();
        idle(); bus.cp0_addr = 5'd12;
        expect_out("sr_write_clr", SEL_RDATA, 32'h0000_FC01);
        expect_out("sr_write_clr_req", SEL_REQ, 32'h0);
        tick();

        // IE = 0 masks interrupts
        idle(); bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_FC00; tick();
        idle(); bus.hw_int = 6'h3F; bus.cp0_addr = 5'd12;
        expect_out("ie0_sr", SEL_RDATA, 32'h0000_FC00);
        expect_out("ie0_req", SEL_REQ, 32'h0);
        tick();

        // Unaligned victim PC and unmapped address read
        idle(); bus.exc_code_in = 5'd2; bus.vpc = 32'h0000_1237; bus.cp0_addr = 5'd16;
        expect_out("unaligned_req", SEL_REQ, 32'h1);
        expect_out("unmapped_rd", SEL_RDATA, 32'h0);
        tick();
        idle(); bus.cp0_addr = 5'd14; bus.exl_clr = 1'b1;
        expect_out("unaligned_epc", SEL_RDATA, 32'h0000_1234);
        tick();

        // Reset during an exception: no capture
        idle(); bus.exc_code_in = 5'd3; bus.vpc = 32'h0000_7000;
        expect_out("pre_reset_req", SEL_REQ, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(); bus.cp0_addr = 5'd14;
        expect_out("mid_rst_epcreg", SEL_RDATA, 32'h0);
        expect_out("mid_rst_epc", SEL_EPC, 32'h0);
        expect_out("mid_rst_req", SEL_REQ, 32'h0);
        tick();
        idle(); bus.cp0_addr = 5'd13; bus.hw_int = 6'h3F;
        expect_out("mid_rst_cause", SEL_RDATA, 32'h0);
        expect_out("mid_rst_int_masked", SEL_REQ, 32'h0);
        tick();
        idle(); bus.cp0_addr = 5'd13;
        expect_out("ip_late", SEL_RDATA, 32'h0000_FC00);
        tick();

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
